// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op encodings, FSM states and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitudes for signed ops and the final sign
// correction of the unsigned core result (mul and div).
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sgn_i,
  output logic [W-1:0] a_mag_o,
  output logic [W-1:0] b_mag_o,
  output logic         a_neg_o,
  output logic         b_neg_o,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic         is_div_i,
  input  logic         neg_hi_i,
  input  logic         neg_lo_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_neg;

  // Magnitudes on the way in, negation of product or
  // quotient/remainder on the way out.
  always_comb begin
    a_neg_o  = sgn_i & a_i[W-1];
    b_neg_o  = sgn_i & b_i[W-1];
    a_mag_o  = a_neg_o ? -a_i : a_i;
    b_mag_o  = b_neg_o ? -b_i : b_i;
    prod     = {hi_i, lo_i};
    prod_neg = -prod;
    if (!is_div_i) begin
      {hi_o, lo_o} = neg_lo_i ? prod_neg : prod;
    end else begin
      hi_o = neg_hi_i ? -hi_i : hi_i;
      lo_o = neg_lo_i ? -lo_i : lo_i;
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owning HI/LO.
// Define MULDIV_FAST_MULT_EN for a one-shot combinational multiply.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic is_div_q, is_div_d;
  logic neg_hi_q, neg_hi_d;
  logic neg_lo_q, neg_lo_d;
  logic zero_q, zero_d;
  logic done_q, done_d;
  logic dbz_q, dbz_d;

  logic is_mul_op, is_div_op, sgn_op;
  logic [XLEN-1:0] a_mag, b_mag;
  logic a_neg, b_neg;
  logic [XLEN-1:0] fix_hi, fix_lo;
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_sh;
  logic [XLEN:0] div_diff;

  assign is_mul_op = (op == OP_MULT) | (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV) | (op == OP_DIVU);
  assign sgn_op    = (op == OP_MULT) | (op == OP_DIV);

  muldiv_sign_fix #(.W(XLEN)) u_sign_fix (
    .a_i      (A),
    .b_i      (B),
    .sgn_i    (sgn_op),
    .a_mag_o  (a_mag),
    .b_mag_o  (b_mag),
    .a_neg_o  (a_neg),
    .b_neg_o  (b_neg),
    .hi_i     (rem_q),
    .lo_i     (quo_q),
    .is_div_i (is_div_q),
    .neg_hi_i (neg_hi_q),
    .neg_lo_i (neg_lo_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // State register and all datapath flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
      neg_lo_q <= neg_lo_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next state: zero divisor (and fast multiply) skip CALC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && is_div_op) begin
          state_d = (B == '0) ? FIX : CALC;
        end else if (start && is_mul_op) begin
`ifdef MULDIV_FAST_MULT_EN
          state_d = FIX;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, one iteration per CALC edge,
  // signed fixup and HI/LO write in FIX.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    neg_lo_d = neg_lo_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    mul_sum  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    div_sh   = {rem_q, quo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = is_div_op;
          zero_d   = is_div_op & (B == '0);
          cnt_d    = CNT_W'(XLEN - 1);
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = is_div_op ? a_neg : (a_neg ^ b_neg);
          case (op)
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
              {rem_d, quo_d} = {{XLEN{1'b0}}, a_mag}
                             * {{XLEN{1'b0}}, b_mag};
`else
              rem_d = '0;
              quo_d = b_mag;
`endif
              opb_d = a_mag;
            end
            OP_DIV, OP_DIVU: begin
              rem_d = '0;
              quo_d = a_mag;
              opb_d = b_mag;
            end
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!is_div_q) begin
          rem_d = mul_sum[XLEN:1];
          quo_d = {mul_sum[0], quo_q[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
          rem_d = div_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = div_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
      end
      FIX: begin
        done_d = 1'b1;
        dbz_d  = zero_q;
        if (!zero_q) begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
      end
      default: ;
    endcase
  end

  // Outputs straight from state and flops.
  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    div_by_zero = dbz_q;
    HI          = hi_q;
    LO          = lo_q;
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: arithmetic reference
// model, per-cycle compare, directed literal cases, random traffic.
module tb_muldiv_hilo_unit;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_L = 1;
`else
  localparam int MUL_L = 33;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dbz;
  int          m_rem;
  logic [64:0] p_res;

  muldiv_hilo_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Result as {div_by_zero, HI, LO} from plain arithmetic.
  function automatic logic [64:0] calc(input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] h, input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    calc = {1'b0, h, l};
    case (o)
      3'd0: begin p = sa * sb; calc = {1'b0, p}; end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        calc = {1'b0, p};
      end
      3'd2: begin
        if (b == 0) calc = {1'b1, h, l};
        else begin
          q = sa / sb;
          r = sa % sb;
          calc = {1'b0, r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) calc = {1'b1, h, l};
        else calc = {1'b0, a % b, a / b};
      end
      3'd4: calc = {1'b0, a, l};
      3'd5: calc = {1'b0, h, a};
      default: calc = {1'b0, h, l};
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] o,
                                input logic [31:0] b);
    case (o)
      3'd0, 3'd1: lat_of = MUL_L;
      3'd2, 3'd3: lat_of = (b == 0) ? 1 : 33;
      3'd4, 3'd5: lat_of = 0;
      default:    lat_of = -1;
    endcase
  endfunction

  // Model: an accepted start produces its result L edges later.
  always @(posedge CLK) begin
    if (RST) begin
      m_hi <= '0; m_lo <= '0;
      m_done <= 1'b0; m_dbz <= 1'b0;
      m_rem <= 0;
    end else if (m_rem > 1) begin
      m_rem <= m_rem - 1;
      m_done <= 1'b0; m_dbz <= 1'b0;
    end else if (m_rem == 1) begin
      m_rem <= 0;
      m_done <= 1'b1;
      {m_dbz, m_hi, m_lo} <= p_res;
    end else begin
      m_done <= 1'b0; m_dbz <= 1'b0;
      if (start && lat_of(op, B) == 0) begin
        m_done <= 1'b1;
        {m_dbz, m_hi, m_lo} <= calc(op, A, B, m_hi, m_lo);
      end else if (start && lat_of(op, B) > 0) begin
        m_rem <= lat_of(op, B);
        p_res <= calc(op, A, B, m_hi, m_lo);
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", busy, m_rem > 0);
      chk("done", done, m_done);
      if (m_done) chk("div_by_zero", div_by_zero, m_dbz);
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
    end
  end

  task automatic do_op(input string nm, input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] ehi, input logic [31:0] elo,
      input logic edbz, input int elat);
    int n;
    start = 1'b1; op = o; A = a; B = b;
    @(negedge CLK);
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    n = 0;
    while (!done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_hi"}, HI, ehi);
    chk({nm, "_lo"}, LO, elo);
    chk({nm, "_dbz"}, div_by_zero, edbz);
    @(negedge CLK);
  endtask

  initial begin
    int sel;
    RST = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dbz", div_by_zero, 1'b0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    do_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MUL_L);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_L);
    do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    do_op("divu", 3'd3, 32'd7, 32'd2,
          32'd1, 32'd3, 1'b0, 33);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 32'h8000_0000, 1'b0, 33);
    do_op("div_zero", 3'd2, 32'd55, 32'd0,
          32'h0, 32'h8000_0000, 1'b1, 1);
    do_op("divu_zero", 3'd3, 32'd9, 32'd0,
          32'h0, 32'h8000_0000, 1'b1, 1);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd4; A = 32'h1234;
    @(negedge CLK);
    chk("mthi_done", done, 1'b1);
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", busy, 1'b0);
    op = 3'd5; A = 32'h5678;
    @(negedge CLK);
    start = 1'b0;
    chk("mtlo_done", done, 1'b1);
    chk("mtlo_hi", HI, 32'h1234);
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_busy", busy, 1'b0);
    @(negedge CLK);
    chk("mt_done_drop", done, 1'b0);

    // ignored start while busy, then abort by reset
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge CLK);
    start = 1'b0;
    repeat (9) @(negedge CLK);
    start = 1'b1; op = 3'd4; A = 32'hBEEF;
    @(negedge CLK);
    start = 1'b0;
    chk("ign_busy", busy, 1'b1);
    chk("ign_hi", HI, 32'h1234);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    chk("abort_busy", busy, 1'b0);
    repeat (20) begin
      @(negedge CLK);
      chk("abort_nodone", done, 1'b0);
    end

    // random traffic, including starts while busy
    for (int i = 0; i < 3000; i++) begin
      sel   = int'($urandom_range(0, 7));
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom);
      A     = $urandom;
      B     = $urandom;
      case (sel)
        0: B = 32'h0;
        1: begin A = 32'h8000_0000; B = 32'hFFFF_FFFF; end
        2: begin A = $urandom_range(0, 20);
                 B = $urandom_range(1, 5); end
        3: B = -32'($urandom_range(1, 9));
        default: ;
      endcase
      RST = ($urandom_range(0, 999) == 0);
      @(negedge CLK);
    end
    start = 1'b0; RST = 1'b0;
    repeat (40) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
